// File: rtl/alu_pkg.sv
// Shared definitions for the digit-serial ALU: opcode encoding, FSM states,
// and the digit-count helper.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_AND  = 3'd0,
    ALU_OR   = 3'd1,
    ALU_XOR  = 3'd2,
    ALU_NOR  = 3'd3,
    ALU_ADD  = 3'd4,
    ALU_SUB  = 3'd5,
    ALU_SLT  = 3'd6,
    ALU_RSVD = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  function automatic int unsigned calc_ndig(input int unsigned width,
                                            input int unsigned digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/alu_digit_slice.sv
// Combinational DIGIT-bit ALU slice. SLT is only decoded as a subtraction
// when ALU_SERIAL_SLT_EN is defined; otherwise opcode 6 is reserved.
module alu_digit_slice
  import alu_pkg::*;
#(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  input  alu_op_e          op,
  output logic [DIGIT-1:0] res,
  output logic             cout,
  output logic             c_top
);

  logic             sub;
  logic [DIGIT-1:0] bx;
  logic [DIGIT:0]   sum;

  always_comb begin
    sub   = (op == ALU_SUB) || (op == ALU_SLT);
    bx    = sub ? ~b : b;
    sum   = {1'b0, a} + {1'b0, bx} + {{DIGIT{1'b0}}, cin};
    cout  = sum[DIGIT];
    // carry into the top bit recovered from that bit's sum
    c_top = a[DIGIT-1] ^ bx[DIGIT-1] ^ sum[DIGIT-1];
    case (op)
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_XOR: res = a ^ b;
      ALU_NOR: res = ~(a | b);
      ALU_ADD: res = sum[DIGIT-1:0];
      ALU_SUB: res = sum[DIGIT-1:0];
`ifdef ALU_SERIAL_SLT_EN
      ALU_SLT: res = sum[DIGIT-1:0];
`endif
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_serial_n_bit.sv
// Digit-serial WIDTH-bit ALU, DIGIT bits per cycle, LSB digit first, with
// valid/ready on both sides. ALU_SERIAL_SLT_EN enables signed set-less-than.
module alu_serial_n_bit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NDIG = calc_ndig(WIDTH, DIGIT);
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if ((DIGIT == 0) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
    $error("alu_serial_n_bit: DIGIT must be nonzero and divide WIDTH");
  end

  state_e           state_q, state_d;
  alu_op_e          op_q, op_d, op_in;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, zacc_q, zacc_d;
  logic             carry_out_q, carry_out_d, overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic [DIGIT-1:0] a_dig, b_dig, r_dig;
  logic             s_cout, s_ctop, arith;

  assign op_in = alu_op_e'(ALUop);
  assign a_dig = a_q[cnt_q*DIGIT +: DIGIT];
  assign b_dig = b_q[cnt_q*DIGIT +: DIGIT];

  alu_digit_slice #(.DIGIT(DIGIT)) u_slice (
    .a     (a_dig),
    .b     (b_dig),
    .cin   (carry_q),
    .op    (op_q),
    .res   (r_dig),
    .cout  (s_cout),
    .c_top (s_ctop)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    zacc_d      = zacc_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    arith       = (op_q == ALU_ADD) || (op_q == ALU_SUB);
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b;
        op_d    = op_in;
        cnt_d   = '0;
        zacc_d  = 1'b0;
        carry_d = (op_in == ALU_SUB) || (op_in == ALU_SLT);
        state_d = BUSY;
      end
      BUSY: begin
        result_d[cnt_q*DIGIT +: DIGIT] = r_dig;
        carry_d = s_cout;
        zacc_d  = zacc_q | (|r_dig);
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d     = DONE;
          cnt_d       = '0;
          carry_out_d = arith & s_cout;
          overflow_d  = arith & (s_cout ^ s_ctop);
          zero_d      = ~(zacc_q | (|r_dig));
`ifdef ALU_SERIAL_SLT_EN
          // SLT replaces the whole difference with the sign of the true result (N ^ V)
          if (op_q == ALU_SLT) begin
            result_d    = '0;
            result_d[0] = r_dig[DIGIT-1] ^ s_cout ^ s_ctop;
            zero_d      = ~(r_dig[DIGIT-1] ^ s_cout ^ s_ctop);
          end
`endif
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= ALU_AND;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      zacc_q      <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      zacc_q      <= zacc_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_serial_n_bit.sv
// Scoreboard bench for alu_serial_n_bit at WIDTH=8, DIGIT=2: the driver
// pushes reference results, a monitor pops and compares on each handshake.
module tb_alu_serial_n_bit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0]   ALUop = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         carry_out, overflow, zero;

  alu_serial_n_bit #(.WIDTH(W), .DIGIT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ALUop     (ALUop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   stall_req = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
  endtask

  // Reference: plain integer arithmetic on the full operands.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int sx, sy, s;
    sx = $signed(x);
    sy = $signed(y);
    e.r = '0; e.c = 1'b0; e.v = 1'b0; e.acc = 0;
    case (op)
      3'd0: e.r = x & y;
      3'd1: e.r = x | y;
      3'd2: e.r = x ^ y;
      3'd3: e.r = ~(x | y);
      3'd4: begin
        s   = int'(x) + int'(y);
        e.r = W'(s);
        e.c = (s > 255);
        e.v = ((sx + sy) > 127) || ((sx + sy) < -128);
      end
      3'd5: begin
        e.r = W'(int'(x) - int'(y));
        e.c = (x >= y);
        e.v = ((sx - sy) > 127) || ((sx - sy) < -128);
      end
`ifdef ALU_SERIAL_SLT_EN
      3'd6: e.r = (sx < sy) ? 8'd1 : 8'd0;
`endif
      default: e.r = '0;
    endcase
    e.z = (e.r == 0);
    return e;
  endfunction

  task automatic send(input logic [2:0] op, input logic [W-1:0] xa, input logic [W-1:0] xb);
    exp_t e;
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b1; ALUop = op; a = xa; b = xb;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
    end else begin
      e = model(op, xa, xb);
      e.acc = cyc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); ALUop = 3'($urandom);
    end
  endtask

  // Monitor: owns out_ready, checks latency, stability under backpressure
  // and the popped expected result on each handshake.
  initial begin : monitor
    exp_t         e;
    logic         seen = 1'b0, stalled = 1'b0, hs_prev = 1'b0, rdy;
    logic [W-1:0] s_r;
    logic         s_c, s_v, s_z;
    int           stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0; stalled = 1'b0; hs_prev = 1'b0; stall_cnt = 0;
      end else begin
        if (hs_prev) chk("in_ready_after_hs", in_ready, 1);
        hs_prev = 1'b0;
        if (out_valid && sb.size() == 0) begin
          chk("spurious_out_valid", out_valid, 0);
          out_ready = 1'b1;
        end else if (out_valid) begin
          e = sb[0];
          if (!seen) begin
            chk("latency", cyc - e.acc, 5);
            if (stall_req > 0) begin
              stall_cnt = stall_req;
              stall_req = 0;
            end
          end
          seen = 1'b1;
          chk("in_ready_in_done", in_ready, 0);
          if (stalled) begin
            chk("hold_result", result, s_r);
            chk("hold_carry", carry_out, s_c);
            chk("hold_ovf", overflow, s_v);
            chk("hold_zero", zero, s_z);
          end
          if (stall_cnt > 0) begin
            rdy = 1'b0;
            stall_cnt--;
          end else begin
            rdy = ($urandom_range(0, 3) != 0);
          end
          out_ready = rdy;
          if (rdy) begin
            chk("result", result, e.r);
            chk("carry_out", carry_out, e.c);
            chk("overflow", overflow, e.v);
            chk("zero", zero, e.z);
            void'(sb.pop_front());
            seen = 1'b0; stalled = 1'b0; hs_prev = 1'b1;
          end else begin
            s_r = result; s_c = carry_out; s_v = overflow; s_z = zero;
            stalled = 1'b1;
          end
        end else begin
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int waited;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_result", result, 0);
    chk("rst_flags", {carry_out, overflow, zero}, 0);
    rst_n = 1'b1;

    send(3'd4, 8'h7F, 8'h01);
    send(3'd5, 8'h05, 8'h05);
    send(3'd5, 8'h00, 8'h01);
    send(3'd3, 8'hF0, 8'h0F);
    send(3'd2, 8'hAA, 8'hFF);
    send(3'd0, 8'hC3, 8'h3C);
    send(3'd1, 8'hC3, 8'h3C);

    // backpressure with a second op already waiting on in_valid
    stall_req = 3;
    send(3'd4, 8'h12, 8'h34);
    send(3'd5, 8'h50, 8'h20);

    // reset in the second BUSY cycle discards the op
    waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_before_reset", sb.size(), 0);
    send(3'd4, 8'h40, 8'h40);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    send(3'd4, 8'h01, 8'h01);

    send(3'd6, 8'h80, 8'h01);
    send(3'd6, 8'h05, 8'h03);
    send(3'd7, 8'h12, 8'h34);
    send(3'd4, 8'hFF, 8'h01);
    send(3'd5, 8'h80, 8'h01);

    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
    end

    waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_end", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
